overlay_draw_controller: RTL and testbench
==========================================

// Module: overlay_draw_controller
// PURPOSE
//  Downstream sequencer for the full-screen overlay drawers (stage-clear / game-over banners).
//  On a start request from the game FSM, it holds every drawer in reset except the selected one.
//  It releases that drawer, gates its raw x/y/colour stream into VGA-adapter write cycles and
//  detects end-of-image. It then returns the drawer to reset and pulses done back to the game FSM.
// PARAMETERS
//  NUM_SRC      4     number of attached drawers (1..4)
//  SEL_W        2     width of overlay_sel
//  X_W / Y_W    8 / 7 VGA coordinate widths
//  COLOUR_W     9     colour width (3 bits per channel)
//  PRIME_CYCLES 2     cycles from drawer release to its first valid pixel
//  TIMEOUT      3300  watchdog limit in DRAW, in cycles (80x40 image = 3200 pixels, plus margin)
// PORTS
//  clk            in   1                   system clock
//  resetn         in   1                   async active-low reset
//  start          in   1                   1-cycle request to draw overlay_sel
//  overlay_sel    in   SEL_W               drawer index, sampled with start
//  src_done       in   NUM_SRC             per-drawer done flags
//  src_x          in   NUM_SRC*X_W         packed drawer x (drawer i = slice i)
//  src_y          in   NUM_SRC*Y_W         packed drawer y
//  src_colour     in   NUM_SRC*COLOUR_W    packed drawer colour
//  src_resetn     out  NUM_SRC             per-drawer sync reset, active low
//  vga_x          out  X_W                 registered pixel x
//  vga_y          out  Y_W                 registered pixel y
//  vga_colour     out  COLOUR_W            registered pixel colour
//  vga_plot       out  1                   registered VGA write enable
//  busy           out  1                   high outside IDLE
//  done           out  1                   1-cycle completion pulse
//  pixel_count    out  12                  pixels plotted in the last or current draw
//  error          out  1                   sticky; see BEHAVIOUR / CONFIGURATION
// BEHAVIOUR
//  Reset (async): state=IDLE; src_resetn=0; vga_x/y/colour=0; vga_plot=0; busy=0; done=0;
//   pixel_count=0; error=0.
//  Drawer contract: after release at cycle R, pixel k is valid at R+PRIME_CYCLES+k.
//   src_done rises in the same cycle the last pixel is presented.
//  FSM states:
//   IDLE  : if start and overlay_sel<NUM_SRC, latch sel, clear pixel_count, go to PRIME.
//           If start and overlay_sel>=NUM_SRC, set error and stay in IDLE.
//   PRIME : src_resetn[sel]=1. Count PRIME_CYCLES-1 further cycles, then go to DRAW.
//   DRAW  : src_resetn[sel]=1. Every cycle, register slice sel into vga_*, set vga_plot=1 and
//           increment pixel_count. If src_done[sel]=1, that pixel is still plotted and the
//           FSM goes to DONE.
//   DONE  : src_resetn=0; vga_plot=0; done=1 for exactly this cycle; next state IDLE.
//  Latency: vga_* lags the source by 1 cycle.
//   An 80x40 image gives exactly 3200 vga_plot cycles and pixel_count=3200.
//  start is ignored outside IDLE; overlay_sel is ignored without start.
//  src_done of non-selected drawers is ignored. src_done[sel] seen during PRIME is ignored.
//  Outside DRAW, vga_x/y/colour hold their last value.
//  pixel_count saturates at 4095.
//  Async reset mid-draw: immediate IDLE, all drawers back in reset, no done pulse.
//  error clears only on reset.
// CONFIGURATION
//  OVERLAY_TIMEOUT_EN defined:
//   A 12-bit watchdog counts DRAW cycles. Reaching TIMEOUT without src_done[sel] sets error
//   and forces DONE; done still pulses.
//  Not defined:
//   No watchdog. DRAW waits indefinitely for src_done[sel]. error reflects only a bad select.
// STRUCTURE
//  overlay_defs.vh: state encodings (IDLE/PRIME/DRAW/DONE) and the default widths and
//   PRIME_CYCLES/TIMEOUT, shared with the game FSM and the drawers.
//  Sub-module overlay_src_mux: combinational slice select of src_x/src_y/src_colour by sel.
//   The top level keeps the FSM, counters and output registers.
// TESTING
//  1. Model drawer (80x40 raster, done at the last pixel); start, sel=2 -> src_resetn=4'b0100
//     in PRIME/DRAW, 3200 plots (first (0,0), last (79,39)), done 1 cycle, pixel_count=3200.
//  2. start pulsed again mid-DRAW with sel=1 -> ignored; sel 2 completes unchanged.
//  3. start, sel=3 with NUM_SRC=3 -> error=1, no src_resetn release, busy stays 0.
//  4. resetn low at pixel 1000 -> all outputs at reset values immediately; no done pulse.
//     A new start works.
//  5. OVERLAY_TIMEOUT_EN, drawer that never asserts done -> error=1 and done pulse after
//     3300 DRAW cycles. Without the macro, busy stays high.
//  6. Back-to-back starts, sel 0 then sel 1 (start on the cycle after done) -> two complete
//     images; src_resetn never has two bits high.

Source files
------------

// File: rtl/overlay_draw_controller_pkg.sv
// Shared definitions for the overlay draw controller: FSM state encoding,
// default geometry / timing values and a select range helper.
package overlay_draw_controller_pkg;

    localparam int DEF_NUM_SRC      = 4;
    localparam int DEF_SEL_W        = 2;
    localparam int DEF_X_W          = 8;
    localparam int DEF_Y_W          = 7;
    localparam int DEF_COLOUR_W     = 9;
    localparam int DEF_PRIME_CYCLES = 2;
    localparam int DEF_TIMEOUT      = 3300;
    localparam int PIX_CNT_W        = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } ovl_state_t;

    // True when a requested drawer index refers to an attached drawer.
    function automatic logic sel_in_range(input int sel, input int num_src);
        return (sel < num_src);
    endfunction

endpackage

// File: rtl/overlay_draw_controller_src_mux.sv
// Combinational slice select of the packed drawer buses by the latched
// drawer index. Indices beyond NUM_SRC select zeros.
module overlay_draw_controller_src_mux
    import overlay_draw_controller_pkg::*;
#(
    parameter int NUM_SRC  = DEF_NUM_SRC,
    parameter int SEL_W    = DEF_SEL_W,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int COLOUR_W = DEF_COLOUR_W
) (
    input  logic [SEL_W-1:0]            sel,
    input  logic [NUM_SRC-1:0]          src_done,
    input  logic [NUM_SRC*X_W-1:0]      src_x,
    input  logic [NUM_SRC*Y_W-1:0]      src_y,
    input  logic [NUM_SRC*COLOUR_W-1:0] src_colour,
    output logic                        sel_done,
    output logic [X_W-1:0]              sel_x,
    output logic [Y_W-1:0]              sel_y,
    output logic [COLOUR_W-1:0]         sel_colour
);

    // Pick the slice belonging to the selected drawer.
    always_comb begin
        sel_done   = 1'b0;
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_done   = src_done[i];
                sel_x      = src_x[i*X_W +: X_W];
                sel_y      = src_y[i*Y_W +: Y_W];
                sel_colour = src_colour[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

endmodule

// File: rtl/overlay_draw_controller.sv
// Overlay draw controller: releases one full-screen overlay drawer at a time,
// turns its pixel stream into registered VGA write cycles and reports
// completion back to the game FSM.
// Optional macro OVERLAY_TIMEOUT_EN adds a DRAW-state watchdog that forces
// completion and flags error when the drawer never signals done.
//
//  state | meaning
//  IDLE  | all drawers in reset, waiting for start
//  PRIME | selected drawer released, waiting for its first valid pixel
//  DRAW  | forwarding one pixel per cycle until the drawer reports done
//  DONE  | drawer back in reset, done pulse high, returning to IDLE
module overlay_draw_controller
    import overlay_draw_controller_pkg::*;
#(
    parameter int NUM_SRC      = DEF_NUM_SRC,
    parameter int SEL_W        = DEF_SEL_W,
    parameter int X_W          = DEF_X_W,
    parameter int Y_W          = DEF_Y_W,
    parameter int COLOUR_W     = DEF_COLOUR_W,
    parameter int PRIME_CYCLES = DEF_PRIME_CYCLES
`ifdef OVERLAY_TIMEOUT_EN
    ,
    parameter int TIMEOUT      = DEF_TIMEOUT
`endif
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    input  logic [SEL_W-1:0]            overlay_sel,
    input  logic [NUM_SRC-1:0]          src_done,
    input  logic [NUM_SRC*X_W-1:0]      src_x,
    input  logic [NUM_SRC*Y_W-1:0]      src_y,
    input  logic [NUM_SRC*COLOUR_W-1:0] src_colour,
    output logic [NUM_SRC-1:0]          src_resetn,
    output logic [X_W-1:0]              vga_x,
    output logic [Y_W-1:0]              vga_y,
    output logic [COLOUR_W-1:0]         vga_colour,
    output logic                        vga_plot,
    output logic                        busy,
    output logic                        done,
    output logic [PIX_CNT_W-1:0]        pixel_count,
    output logic                        error
);

    localparam int PC_W = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;

    ovl_state_t             state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [PC_W-1:0]        prime_cnt_q, prime_cnt_d;
    logic [NUM_SRC-1:0]     src_resetn_q, src_resetn_d;
    logic [X_W-1:0]         vga_x_q, vga_x_d;
    logic [Y_W-1:0]         vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0]    vga_colour_q, vga_colour_d;
    logic                   vga_plot_q, vga_plot_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [PIX_CNT_W-1:0]   pixel_count_q, pixel_count_d;
    logic                   error_q, error_d;
`ifdef OVERLAY_TIMEOUT_EN
    logic [PIX_CNT_W-1:0]   wd_q, wd_d;
`endif

    logic                   sel_done;
    logic [X_W-1:0]         sel_x;
    logic [Y_W-1:0]         sel_y;
    logic [COLOUR_W-1:0]    sel_colour;
    logic [NUM_SRC-1:0]     rel_mask;

    overlay_draw_controller_src_mux #(
        .NUM_SRC  (NUM_SRC),
        .SEL_W    (SEL_W),
        .X_W      (X_W),
        .Y_W      (Y_W),
        .COLOUR_W (COLOUR_W)
    ) u_src_mux (
        .sel        (sel_q),
        .src_done   (src_done),
        .src_x      (src_x),
        .src_y      (src_y),
        .src_colour (src_colour),
        .sel_done   (sel_done),
        .sel_x      (sel_x),
        .sel_y      (sel_y),
        .sel_colour (sel_colour)
    );

    // One-hot release mask for the drawer requested on start.
    always_comb begin
        rel_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (overlay_sel == SEL_W'(i)) rel_mask[i] = 1'b1;
        end
    end

    // Next-state and next-output logic; outputs are registered so they
    // line up with the state they belong to.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        prime_cnt_d   = prime_cnt_q;
        src_resetn_d  = src_resetn_q;
        vga_x_d       = vga_x_q;
        vga_y_d       = vga_y_q;
        vga_colour_d  = vga_colour_q;
        vga_plot_d    = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        pixel_count_d = pixel_count_q;
        error_d       = error_q;
`ifdef OVERLAY_TIMEOUT_EN
        wd_d          = wd_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (sel_in_range(int'(overlay_sel), NUM_SRC)) begin
                        state_d       = ST_PRIME;
                        sel_d         = overlay_sel;
                        pixel_count_d = '0;
                        prime_cnt_d   = PC_W'(PRIME_CYCLES - 1);
                        src_resetn_d  = rel_mask;
                        busy_d        = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_PRIME: begin
                // Drawer output is not valid yet; its done flag is ignored here.
                if (prime_cnt_q == '0) begin
                    state_d = ST_DRAW;
`ifdef OVERLAY_TIMEOUT_EN
                    wd_d    = PIX_CNT_W'(TIMEOUT - 1);
`endif
                end else begin
                    prime_cnt_d = prime_cnt_q - 1'b1;
                end
            end
            ST_DRAW: begin
                vga_x_d      = sel_x;
                vga_y_d      = sel_y;
                vga_colour_d = sel_colour;
                vga_plot_d   = 1'b1;
                if (pixel_count_q != '1) pixel_count_d = pixel_count_q + 1'b1;
                if (sel_done) begin
                    state_d      = ST_DONE;
                    src_resetn_d = '0;
                    done_d       = 1'b1;
                end
`ifdef OVERLAY_TIMEOUT_EN
                else if (wd_q == '0) begin
                    state_d      = ST_DONE;
                    src_resetn_d = '0;
                    done_d       = 1'b1;
                    error_d      = 1'b1;
                end else begin
                    wd_d = wd_q - 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                src_resetn_d = '0;
                busy_d       = 1'b0;
            end
            default: begin
                state_d      = ST_IDLE;
                src_resetn_d = '0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            prime_cnt_q   <= '0;
            src_resetn_q  <= '0;
            vga_x_q       <= '0;
            vga_y_q       <= '0;
            vga_colour_q  <= '0;
            vga_plot_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pixel_count_q <= '0;
            error_q       <= 1'b0;
`ifdef OVERLAY_TIMEOUT_EN
            wd_q          <= '0;
`endif
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            prime_cnt_q   <= prime_cnt_d;
            src_resetn_q  <= src_resetn_d;
            vga_x_q       <= vga_x_d;
            vga_y_q       <= vga_y_d;
            vga_colour_q  <= vga_colour_d;
            vga_plot_q    <= vga_plot_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pixel_count_q <= pixel_count_d;
            error_q       <= error_d;
`ifdef OVERLAY_TIMEOUT_EN
            wd_q          <= wd_d;
`endif
        end
    end

    assign src_resetn  = src_resetn_q;
    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_colour  = vga_colour_q;
    assign vga_plot    = vga_plot_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pixel_count = pixel_count_q;
    assign error       = error_q;

endmodule

// File: tb/tb_overlay_draw_controller.sv
// Bench for overlay_draw_controller with three raster drawer models.
// Exercises OVERLAY_TIMEOUT_EN when the macro is defined.
module tb_overlay_draw_controller;

    localparam int N       = 3;
    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int C_W     = 9;
    localparam int SEL_W   = 2;
    localparam int TIMEOUT = 3300;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                start = 1'b0;
    logic [SEL_W-1:0]    overlay_sel = '0;
    logic [N-1:0]        src_done;
    logic [N*X_W-1:0]    src_x;
    logic [N*Y_W-1:0]    src_y;
    logic [N*C_W-1:0]    src_colour;
    logic [N-1:0]        src_resetn;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [C_W-1:0]      vga_colour;
    logic                vga_plot;
    logic                busy;
    logic                done;
    logic [11:0]         pixel_count;
    logic                error;

    int  vectors    = 0;
    int  miscompares = 0;
    bit  exp_err    = 1'b0;

    int          img_w [N];
    int          img_h [N];
    bit          never_done [N];
    int unsigned cyc [N];
    logic [N-1:0] noise_done = '0;

    overlay_draw_controller #(
        .NUM_SRC  (N),
        .SEL_W    (SEL_W),
        .X_W      (X_W),
        .Y_W      (Y_W),
        .COLOUR_W (C_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .overlay_sel (overlay_sel),
        .src_done    (src_done),
        .src_x       (src_x),
        .src_y       (src_y),
        .src_colour  (src_colour),
        .src_resetn  (src_resetn),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .busy        (busy),
        .done        (done),
        .pixel_count (pixel_count),
        .error       (error)
    );

    always #5 clk = ~clk;

    // Drawer models: cycles since release; pixel k appears at cycle 2+k.
    always @(posedge clk or negedge resetn) begin
        for (int i = 0; i < N; i++) begin
            if (!resetn)            cyc[i] <= 0;
            else if (src_resetn[i]) cyc[i] <= cyc[i] + 1;
            else                    cyc[i] <= 0;
        end
    end

    function automatic logic [C_W-1:0] pix_colour(input int k, input int s);
        return C_W'(k * 5 + s * 73 + 11);
    endfunction

    always_comb begin
        src_x      = '0;
        src_y      = '0;
        src_colour = '0;
        src_done   = noise_done;
        for (int i = 0; i < N; i++) begin
            int k;
            k = int'(cyc[i]) - 2;
            if (k >= 0 && img_w[i] > 0) begin
                src_x[i*X_W +: X_W]      = X_W'(k % img_w[i]);
                src_y[i*Y_W +: Y_W]      = Y_W'(k / img_w[i]);
                src_colour[i*C_W +: C_W] = pix_colour(k, i);
                if (!never_done[i] && k == img_w[i] * img_h[i] - 1) src_done[i] = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_resetn", 32'(src_resetn), 0);
        chk("rst_vga", {vga_x, vga_y, vga_colour}, 0);
        chk("rst_plot", 32'(vga_plot), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pixcnt", 32'(pixel_count), 0);
        chk("rst_error", 32'(error), 0);
    endtask

    // One draw request on drawer s with a w x h image. Called just after a negedge.
    task automatic do_draw(input int s, input int w, input int h, input bit mid_start,
                           input int abort_at, input bit hang);
        int idx = 0;
        int n_cyc = 0;
        bit fin = 1'b0;
        int exp_n;
        int budget;
        logic [X_W-1:0] last_x = '0;
        logic [N-1:0] mask;
        mask = N'(1 << s);
        img_w[s] = w;
        img_h[s] = h;
        never_done[s] = hang;
        exp_n = w * h;
`ifdef OVERLAY_TIMEOUT_EN
        if (hang) exp_n = TIMEOUT;
`endif
        budget = hang ? 4200 : exp_n + 20;
        start = 1'b1;
        overlay_sel = SEL_W'(s);
        @(negedge clk);
        start = 1'b0;
        overlay_sel = SEL_W'($urandom_range(0, 3));
        chk("prime_busy", 32'(busy), 1);
        chk("prime_release", 32'(src_resetn), 32'(mask));
        noise_done = mask | N'($urandom);
        @(negedge clk);
        noise_done = N'($urandom) & ~mask;
        while (!fin && n_cyc < budget) begin
            @(negedge clk);
            n_cyc++;
            if (vga_plot) begin
                chk("pixel", {vga_x, vga_y, vga_colour},
                    {X_W'(idx % w), Y_W'(idx / w), pix_colour(idx, s)});
                last_x = X_W'(idx % w);
                idx++;
            end
            chk("release_mask", 32'(src_resetn), done ? 0 : 32'(mask));
            if (done) fin = 1'b1;
            noise_done = N'($urandom) & ~mask;
            if (mid_start && idx == 500) begin
                start = 1'b1;
                overlay_sel = SEL_W'((s + 1) % N);
            end else begin
                start = 1'b0;
            end
            if (abort_at >= 0 && idx == abort_at) begin
                resetn = 1'b0;
                noise_done = '0;
                #1;
                chk_reset_values();
                exp_err = 1'b0;
                @(negedge clk);
                chk("abort_no_done", 32'(done), 0);
                resetn = 1'b1;
                @(negedge clk);
                chk("abort_idle", {done, busy}, 0);
                return;
            end
        end
        noise_done = '0;
        start = 1'b0;
`ifndef OVERLAY_TIMEOUT_EN
        if (hang) begin
            chk("hang_busy", 32'(busy), 1);
            chk("hang_no_done", 32'(fin), 0);
            chk("pixcnt_saturate", 32'(pixel_count), 4095);
            never_done[s] = 1'b0;
            resetn = 1'b0;
            exp_err = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
            @(negedge clk);
            return;
        end
`endif
        if (hang) exp_err = 1'b1;
        never_done[s] = 1'b0;
        chk("done_seen", 32'(fin), 1);
        chk("plot_total", 32'(idx), 32'(exp_n));
        chk("pixel_count", 32'(pixel_count), 32'(exp_n));
        chk("error_flag", 32'(error), 32'(exp_err));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_plot", 32'(vga_plot), 0);
        chk("idle_release", 32'(src_resetn), 0);
        chk("hold_x", 32'(vga_x), 32'(last_x));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            img_w[i] = 80;
            img_h[i] = 40;
            never_done[i] = 1'b0;
        end
        #1;
        chk_reset_values();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Full 80x40 image on drawer 2.
        do_draw(2, 80, 40, 1'b0, -1, 1'b0);
        // Start mid-draw with another select is ignored.
        do_draw(2, 80, 40, 1'b1, -1, 1'b0);

        // Out-of-range select sets error and never releases a drawer.
        start = 1'b1;
        overlay_sel = 2'd3;
        @(negedge clk);
        start = 1'b0;
        exp_err = 1'b1;
        chk("badsel_error", 32'(error), 1);
        repeat (4) begin
            chk("badsel_idle", {busy, src_resetn}, 0);
            @(negedge clk);
        end

        // Async reset at pixel 1000, then a fresh draw.
        do_draw(1, 80, 40, 1'b0, 1000, 1'b0);
        do_draw(0, 10, 5, 1'b0, -1, 1'b0);

        // Drawer that never reports done.
        do_draw(1, 80, 40, 1'b0, -1, 1'b1);

        // Back-to-back requests, start on the cycle after done.
        do_draw(0, 16, 8, 1'b0, -1, 1'b0);
        do_draw(1, 12, 6, 1'b0, -1, 1'b0);

        // Randomised requests and image sizes.
        for (int r = 0; r < 8; r++) begin
            do_draw($urandom_range(0, N - 1), $urandom_range(1, 20), $urandom_range(1, 10),
                    1'b0, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
